// File: rtl/ad_processing.sv
// ---------------------------------------------------------------------------
// ad_processing
//   Associated-data stage of the ACORN-128 datapath. Loads the post-
//   initialization state, absorbs an AD byte stream one bit per clock
//   (LSB first), then runs the 256-step AD padding. One state_update128
//   step is applied per clock in AD_STEP and PAD.
//
// Ports
//   clk          : clock
//   rst_n        : asynchronous active-low reset
//   start_i      : start pulse, honoured in IDLE or DONE only
//   state_in     : 293-bit post-initialization state, sampled on start
//   ad_len_i     : AD length in bytes, sampled on start
//   ad_byte_i    : AD byte
//   ad_valid_i   : ad_byte_i valid
//   ad_ready_o   : byte accepted this cycle when ad_valid_i is high
//   state_out    : current internal state register
//   busy_o       : high in AD_WAIT, AD_STEP and PAD
//   done_o       : high in DONE, state_out final while high
// ---------------------------------------------------------------------------
module ad_processing #(
    parameter int AD_LEN_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic [292:0]        state_in,
    input  logic [AD_LEN_W-1:0] ad_len_i,
    input  logic [7:0]          ad_byte_i,
    input  logic                ad_valid_i,
    output logic                ad_ready_o,
    output logic [292:0]        state_out,
    output logic                busy_o,
    output logic                done_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        AD_WAIT = 3'd1,
        AD_STEP = 3'd2,
        PAD     = 3'd3,
        DONE    = 3'd4
    } fsm_t;

    fsm_t                fsm_q, fsm_d;
    logic [292:0]        state_q;
    logic [292:0]        sup_out;
    logic [AD_LEN_W-1:0] len_q;
    logic [7:0]          byte_q;
    logic [2:0]          bit_cnt_q;
    logic [8:0]          pad_cnt_q;
    logic                ready_q, busy_q, done_q;
    logic                step_m, step_ca;
    logic                accept;

    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic ch(input logic x, input logic y, input logic z);
        return (x & y) ^ (~x & z);
    endfunction

    // One ACORN-128 state update. The six LFSR feedback taps all read the
    // pre-update state, so they can be evaluated in parallel from s_in.
    function automatic logic [292:0] sup128(input logic [292:0] s_in,
                                            input logic m,
                                            input logic ca,
                                            input logic cb);
        logic [292:0] s;
        logic         ks;
        logic         f;
        s      = s_in;
        s[289] = s_in[289] ^ s_in[235] ^ s_in[230];
        s[230] = s_in[230] ^ s_in[196] ^ s_in[193];
        s[193] = s_in[193] ^ s_in[160] ^ s_in[154];
        s[154] = s_in[154] ^ s_in[111] ^ s_in[107];
        s[107] = s_in[107] ^ s_in[66]  ^ s_in[61];
        s[61]  = s_in[61]  ^ s_in[23]  ^ s_in[0];
        ks = s[12] ^ s[154] ^ maj(s[235], s[61], s[193]) ^ ch(s[230], s[111], s[66]);
        f  = s[0] ^ ~s[107] ^ maj(s[244], s[23], s[160]) ^ (ca & s[196]) ^ (cb & ks);
        return {f ^ m, s[292:1]};
    endfunction

    // Per-step message bit and ca control; cb is 1 in every step of this stage.
    always_comb begin
        step_m  = 1'b0;
        step_ca = 1'b1;
        if (fsm_q == AD_STEP) begin
            step_m = byte_q[bit_cnt_q];
        end else if (fsm_q == PAD) begin
            step_m  = (pad_cnt_q == 9'd0);
            step_ca = ~pad_cnt_q[7] & ~pad_cnt_q[8];
        end
    end

    assign sup_out = sup128(state_q, step_m, step_ca, 1'b1);
    assign accept  = (fsm_q == AD_WAIT) && ad_valid_i;

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE, DONE: if (start_i) fsm_d = (ad_len_i == '0) ? PAD : AD_WAIT;
            AD_WAIT:    if (accept) fsm_d = AD_STEP;
            AD_STEP:    if (bit_cnt_q == 3'd7) fsm_d = (len_q != '0) ? AD_WAIT : PAD;
            PAD:        if (pad_cnt_q == 9'd255) fsm_d = DONE;
            default:    fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q     <= IDLE;
            state_q   <= '0;
            len_q     <= '0;
            byte_q    <= '0;
            bit_cnt_q <= '0;
            pad_cnt_q <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        state_q   <= state_in;
                        len_q     <= ad_len_i;
                        bit_cnt_q <= '0;
                        pad_cnt_q <= '0;
                    end
                end
                AD_WAIT: begin
                    if (accept) begin
                        byte_q    <= ad_byte_i;
                        len_q     <= len_q - AD_LEN_W'(1);
                        bit_cnt_q <= '0;
                    end
                end
                AD_STEP: begin
                    state_q   <= sup_out;
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    pad_cnt_q <= '0;
                end
                PAD: begin
                    state_q   <= sup_out;
                    pad_cnt_q <= pad_cnt_q + 9'd1;
                end
                default: ;
            endcase
            fsm_q   <= fsm_d;
            // Outputs are registered from the next state so they line up with fsm_q.
            ready_q <= (fsm_d == AD_WAIT);
            busy_q  <= (fsm_d == AD_WAIT) || (fsm_d == AD_STEP) || (fsm_d == PAD);
            done_q  <= (fsm_d == DONE);
        end
    end

    assign ad_ready_o = ready_q;
    assign state_out  = state_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_ad_processing.sv
// ---------------------------------------------------------------------------
// tb_ad_processing
//   Table-driven bench for ad_processing with a bit-serial ACORN-128
//   reference model, plus hand-written reset and restart sequences.
// ---------------------------------------------------------------------------
module tb_ad_processing;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_i;
    logic [292:0] state_in;
    logic [15:0]  ad_len_i;
    logic [7:0]   ad_byte_i;
    logic         ad_valid_i;
    logic         ad_ready_o;
    logic [292:0] state_out;
    logic         busy_o;
    logic         done_o;

    int checks = 0;
    int errors = 0;
    logic [292:0] init_state;

    always #5 clk = ~clk;

    ad_processing #(.AD_LEN_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .state_in   (state_in),
        .ad_len_i   (ad_len_i),
        .ad_byte_i  (ad_byte_i),
        .ad_valid_i (ad_valid_i),
        .ad_ready_o (ad_ready_o),
        .state_out  (state_out),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    typedef struct {
        string      name;
        int         len;
        logic [7:0] b0, b1, b2;
        bit         use_init;
        int         stall_idx;
        int         stall_n;
        int         inj0, inj1;
        int         a0, a1, a2;
        int         done_edge;
    } vec_t;

    vec_t tbl[5];

    // Reference update written the way the C model does it: in-place taps,
    // then a one-position shift with the feedback bit entering at 292.
    function automatic logic [292:0] model_step(input logic [292:0] st, input bit m,
                                                input bit ca, input bit cb);
        bit s[293];
        bit ks, f, mj1, mj2, chv;
        logic [292:0] r;
        for (int i = 0; i < 293; i++) s[i] = st[i];
        s[289] ^= s[235] ^ s[230];
        s[230] ^= s[196] ^ s[193];
        s[193] ^= s[160] ^ s[154];
        s[154] ^= s[111] ^ s[107];
        s[107] ^= s[66]  ^ s[61];
        s[61]  ^= s[23]  ^ s[0];
        mj1 = (s[235] & s[61]) | (s[235] & s[193]) | (s[61] & s[193]);
        chv = s[230] ? s[111] : s[66];
        ks  = s[12] ^ s[154] ^ mj1 ^ chv;
        mj2 = (s[244] & s[23]) | (s[244] & s[160]) | (s[23] & s[160]);
        f   = s[0] ^ (s[107] ^ 1'b1) ^ mj2 ^ (ca & s[196]) ^ (cb & ks);
        for (int i = 0; i < 292; i++) s[i] = s[i+1];
        s[292] = f ^ m;
        for (int i = 0; i < 293; i++) r[i] = s[i];
        return r;
    endfunction

    function automatic logic [292:0] model_run(input logic [292:0] st, input int len,
                                               input logic [7:0] b0, input logic [7:0] b1,
                                               input logic [7:0] b2);
        logic [7:0]   bytes [3];
        logic [292:0] s;
        logic [7:0]   cur;
        bytes[0] = b0; bytes[1] = b1; bytes[2] = b2;
        s = st;
        for (int k = 0; k < len; k++) begin
            cur = bytes[k];
            for (int j = 0; j < 8; j++) s = model_step(s, cur[j], 1'b1, 1'b1);
        end
        for (int p = 0; p < 256; p++) s = model_step(s, (p == 0), (p < 128), 1'b1);
        return s;
    endfunction

    // Key/IV all zero: every init message bit is 0 except step 256 (K[0]^1).
    function automatic logic [292:0] model_init();
        logic [292:0] s;
        s = '0;
        for (int i = 0; i < 1792; i++) s = model_step(s, (i == 256), 1'b1, 1'b1);
        return s;
    endfunction

    task automatic chk_vec(input string name, input logic [292:0] act, input logic [292:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_case(input vec_t v);
        logic [292:0] sin, exp_state;
        logic [7:0]   bytes [3];
        int           idx, stall_left, edge_n, done_edge, busy_cnt;
        int           acc [3];
        int           exp_acc [3];
        bit           got_done, rdy_b, vld_b;
        bytes[0] = v.b0; bytes[1] = v.b1; bytes[2] = v.b2;
        exp_acc[0] = v.a0; exp_acc[1] = v.a1; exp_acc[2] = v.a2;
        sin       = v.use_init ? init_state : '0;
        exp_state = model_run(sin, v.len, v.b0, v.b1, v.b2);

        @(negedge clk);
        start_i    = 1'b1;
        ad_len_i   = 16'(v.len);
        state_in   = sin;
        ad_valid_i = 1'b1;
        ad_byte_i  = bytes[0];
        @(posedge clk);
        #1;
        start_i = 1'b0;
        edge_n  = 0;
        chk_int({v.name, "_done_after_e0"}, int'(done_o), 0);
        chk_int({v.name, "_busy_after_e0"}, int'(busy_o), 1);
        busy_cnt   = int'(busy_o);
        idx        = 0;
        stall_left = v.stall_n;
        got_done   = 1'b0;
        done_edge  = -1;
        for (int k = 0; k < 3; k++) acc[k] = -1;

        while (!got_done && edge_n < 400) begin
            @(negedge clk);
            start_i   = ((edge_n + 1) == v.inj0) || ((edge_n + 1) == v.inj1);
            ad_byte_i = bytes[(idx < 3) ? idx : 0];
            if (ad_ready_o && idx == v.stall_idx && stall_left > 0) begin
                ad_valid_i = 1'b0;
                stall_left--;
            end else begin
                ad_valid_i = 1'b1;
            end
            rdy_b = ad_ready_o;
            vld_b = ad_valid_i;
            @(posedge clk);
            edge_n++;
            #1;
            if (rdy_b && vld_b) begin
                if (idx < 3) acc[idx] = edge_n;
                idx++;
            end
            if (done_o) begin
                got_done  = 1'b1;
                done_edge = edge_n;
            end else if (busy_o) begin
                busy_cnt++;
            end
        end
        start_i    = 1'b0;
        ad_valid_i = 1'b0;

        chk_int({v.name, "_done_edge"}, done_edge, v.done_edge);
        chk_int({v.name, "_busy_cycles"}, busy_cnt, v.done_edge);
        chk_int({v.name, "_bytes_accepted"}, idx, v.len);
        for (int k = 0; k < v.len && k < 3; k++)
            chk_int($sformatf("%s_accept_edge%0d", v.name, k), acc[k], exp_acc[k]);
        chk_vec({v.name, "_state"}, state_out, exp_state);
        repeat (2) @(posedge clk);
        #1;
        chk_vec({v.name, "_state_hold"}, state_out, exp_state);
        chk_int({v.name, "_done_hold"}, int'(done_o), 1);
    endtask

    initial begin
        rst_n      = 1'b0;
        start_i    = 1'b0;
        state_in   = '0;
        ad_len_i   = '0;
        ad_byte_i  = '0;
        ad_valid_i = 1'b0;
        init_state = model_init();

        tbl[0] = '{"zero_len",   0, 8'h00, 8'h00, 8'h00, 1'b0, -1, 0, 0,   0, -1, -1, -1, 256};
        tbl[1] = '{"three_byte", 3, 8'h01, 8'hA5, 8'hFF, 1'b1, -1, 0, 0,   0,  1, 10, 19, 283};
        tbl[2] = '{"stall",      3, 8'h01, 8'hA5, 8'hFF, 1'b1,  2, 5, 0,   0,  1, 10, 24, 288};
        tbl[3] = '{"start_ign",  3, 8'h01, 8'hA5, 8'hFF, 1'b1, -1, 0, 5, 100,  1, 10, 19, 283};
        tbl[4] = '{"restart",    1, 8'h80, 8'h00, 8'h00, 1'b1, -1, 0, 0,   0,  1, -1, -1, 265};

        repeat (3) @(posedge clk);
        #1;
        chk_vec("reset_state", state_out, '0);
        chk_int("reset_ready", int'(ad_ready_o), 0);
        chk_int("reset_busy", int'(busy_o), 0);
        chk_int("reset_done", int'(done_o), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) run_case(tbl[i]);

        // Asynchronous reset in the middle of a three-byte run.
        @(negedge clk);
        start_i    = 1'b1;
        ad_len_i   = 16'd3;
        state_in   = init_state;
        ad_valid_i = 1'b1;
        ad_byte_i  = 8'h01;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        chk_int("midrun_busy_e100", int'(busy_o), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_vec("async_rst_state", state_out, '0);
        chk_int("async_rst_ready", int'(ad_ready_o), 0);
        chk_int("async_rst_busy", int'(busy_o), 0);
        chk_int("async_rst_done", int'(done_o), 0);
        ad_valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_case(tbl[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ad_processing.md
# ad_processing

Associated-data stage of the ACORN-128 datapath, directly downstream of `initialization`. It takes the 293-bit state produced after the 1792 initialization steps, absorbs a byte stream of associated data one bit per clock, and runs the 256-step AD padding. The resulting state is handed to the plaintext encryption stage. One `state_update128` step is applied per clock, with `ca`/`cb` and the message bit driven per the ACORN-128 AD schedule.

## Interface
Parameters:
- `AD_LEN_W`, default 16: width of the associated-data byte count.

Ports:
- `clk`, in, 1: the single clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start_i`, in, 1: single-cycle start pulse. Honoured only in IDLE or DONE.
- `state_in`, in, 293: post-initialization state (`state_out` of `initialization`). Sampled on the start edge.
- `ad_len_i`, in, `AD_LEN_W`: AD length in bytes. Sampled on the start edge.
- `ad_byte_i`, in, 8: AD byte.
- `ad_valid_i`, in, 1: `ad_byte_i` is valid.
- `ad_ready_o`, out, 1: block accepts a byte this cycle.
- `state_out`, out, 293: current internal state register.
- `busy_o`, out, 1: high in AD_WAIT, AD_STEP and PAD.
- `done_o`, out, 1: high in DONE. `state_out` is final while high.

## Operation
- FSM states: IDLE, AD_WAIT, AD_STEP, PAD, DONE.
- IDLE/DONE with `start_i`=1:
  - `state_r` <= `state_in`; `len_r` <= `ad_len_i`; counters cleared.
  - Next state is PAD if `ad_len_i`==0, else AD_WAIT.
- AD_WAIT:
  - `ad_ready_o`=1; the state register holds.
  - On `ad_valid_i`&`ad_ready_o`: latch the byte, decrement `len_r`, go to AD_STEP with `bit_cnt`=0.
- AD_STEP, 8 cycles:
  - Each cycle: one update with m=`byte_r[bit_cnt]` (LSB first), ca=1, cb=1.
  - After `bit_cnt`==7: go to AD_WAIT if `len_r`!=0, else PAD with `pad_cnt`=0.
- PAD, 256 cycles, `pad_cnt` 0..255 (9-bit counter):
  - m=1 only at `pad_cnt`==0, else 0.
  - ca=1 for `pad_cnt`<128, ca=0 for 128..255; cb=1 throughout.
  - After 255: go to DONE.
- DONE: state holds; `done_o`=1 until the next `start_i` (restart) or reset.
- `ad_valid_i` outside AD_WAIT is ignored; the byte is not consumed.
- `start_i` in AD_WAIT/AD_STEP/PAD is ignored; the run continues unchanged.
- The state register updates only in AD_STEP and PAD (`state_r` <= `sup128_out`), plus the start load.
- Reset (async, any time, including mid-run):
  - FSM=IDLE; `state_r`, `len_r`, `byte_r` and all counters = 0.
  - `state_out`=0, `ad_ready_o`=0, `busy_o`=0, `done_o`=0.
  - A partially absorbed byte is discarded.

## Timing
- Edge 0 = the clock edge sampling `start_i`=1. All outputs are registered or FSM-decoded, with no combinational path from inputs to outputs.
- `ad_len_i`=0:
  - PAD steps occur on edges 1..256.
  - `done_o`=1 from after edge 256; `busy_o`=1 after edges 0..255.
- N bytes, `ad_valid_i` held high:
  - Byte k (k=0..N-1) is accepted on edge 1+9k; its 8 steps occur on edges 2+9k..9+9k.
  - PAD occupies edges 9N+1..9N+256; `done_o` rises after edge 9N+256.
- Each cycle `ad_valid_i` is low in AD_WAIT adds exactly one cycle, with no state change.
- `ad_ready_o` is high only in AD_WAIT, for at most one accepting edge per byte.
- Total AD steps = 8N+256. `len_r` never underflows, because AD_WAIT is entered only with `len_r`>0.

## Test plan
- Zero-length AD: `state_in`=0, `ad_len_i`=0, pulse `start_i` → `done_o` rises after edge 256; `state_out` equals the C golden model after 256 pad steps; `ad_ready_o` is never high.
- Three bytes 0x01, 0xA5, 0xFF, valid always high, with `state_in` from a real `initialization` run (key/IV = 0) → bytes accepted on edges 1, 10, 19; `done_o` after edge 283; `state_out` matches the golden model.
- Stall: same as the previous scenario but `ad_valid_i` low for 5 cycles before byte 2 → `done_o` after edge 288; the final state is identical to the previous scenario.
- `start_i` pulsed during PAD and during AD_STEP → ignored; timing and final state are unchanged.
- `rst_n` low at edge 100 of a 3-byte run → all outputs become 0 immediately (asynchronously). After release, a fresh start with `ad_len_i`=0 reproduces the zero-length result.
- Back-to-back runs: after `done_o`, start again with `ad_len_i`=1, byte 0x80 → `done_o` drops after edge 0, then rises after edge 265; the state matches the model.
